// File: rtl/stall_ctrl_if.sv
// stall_ctrl_if: hazard/stall request and pipeline control bundle.
//   master : pipeline side, drives requests, receives hold/flush/redirect.
//   slave  : stall controller side.
//   Signals: rdy_in, if_req, id_req, mem_req, ex_br, br_target (requests);
//            stall[4:0], flush_ifid, flush_idex, pc_redirect, pc_target (control);
//            stall_cycles, redirect_cnt only when STALL_CNT_EN is defined.
interface stall_ctrl_if;
   localparam int unsigned ADDR_W  = 32;
   localparam int unsigned STALL_W = 5;
   localparam int unsigned SCNT_W  = 32;
   localparam int unsigned RCNT_W  = 16;

   logic                rdy_in;
   logic                if_req;
   logic                id_req;
   logic                mem_req;
   logic                ex_br;
   logic [ADDR_W-1:0]   br_target;
   logic [STALL_W-1:0]  stall;
   logic                flush_ifid;
   logic                flush_idex;
   logic                pc_redirect;
   logic [ADDR_W-1:0]   pc_target;
`ifdef STALL_CNT_EN
   logic [SCNT_W-1:0]   stall_cycles;
   logic [RCNT_W-1:0]   redirect_cnt;

   modport master (
      output rdy_in, if_req, id_req, mem_req, ex_br, br_target,
      input  stall, flush_ifid, flush_idex, pc_redirect, pc_target,
             stall_cycles, redirect_cnt
   );
   modport slave (
      input  rdy_in, if_req, id_req, mem_req, ex_br, br_target,
      output stall, flush_ifid, flush_idex, pc_redirect, pc_target,
             stall_cycles, redirect_cnt
   );
`else
   modport master (
      output rdy_in, if_req, id_req, mem_req, ex_br, br_target,
      input  stall, flush_ifid, flush_idex, pc_redirect, pc_target
   );
   modport slave (
      input  rdy_in, if_req, id_req, mem_req, ex_br, br_target,
      output stall, flush_ifid, flush_idex, pc_redirect, pc_target
   );
`endif
endinterface

// File: rtl/stall_ctrl.sv
// stall_ctrl: pipeline hazard arbiter. Produces same-cycle hold, flush and
// PC redirect controls from stage requests. A taken branch that resolves
// while MEM is busy is parked (FLUSH_PEND + pend_target) and issued once
// MEM frees up.
//   clk_in  : clock, rising edge
//   rst_in  : asynchronous active-high reset; forces all outputs to 0
//   bus     : stall_ctrl_if.slave (requests in, control out)
// Optional feature: define STALL_CNT_EN to add saturating stall_cycles and
// redirect_cnt performance counters on the interface.
module stall_ctrl (
   input  logic         clk_in,
   input  logic         rst_in,
   stall_ctrl_if.slave  bus
);
   localparam int unsigned ADDR_W  = 32;
   localparam int unsigned STALL_W = 5;

   typedef enum logic {
      ST_RUN        = 1'b0,
      ST_FLUSH_PEND = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   pend_q, pend_d;

   logic [STALL_W-1:0]  stall_c;
   logic                flush_ifid_c;
   logic                flush_idex_c;
   logic                redirect_c;
   logic [ADDR_W-1:0]   target_c;

   // State register
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q <= ST_RUN;
         pend_q  <= '0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
      end
   end

   // Priority arbitration: reset, not-ready, MEM busy, pending flush, branch, ID, IF
   always_comb begin
      state_d      = state_q;
      pend_d       = pend_q;
      stall_c      = '0;
      flush_ifid_c = 1'b0;
      flush_idex_c = 1'b0;
      redirect_c   = 1'b0;
      target_c     = '0;
      if (rst_in) begin
         state_d = ST_RUN;
      end else if (!bus.rdy_in) begin
         stall_c = 5'b11111;
      end else if (bus.mem_req) begin
         stall_c = 5'b01111;
         // Only the first branch seen while MEM is busy is remembered
         if (state_q == ST_RUN && bus.ex_br) begin
            state_d = ST_FLUSH_PEND;
            pend_d  = bus.br_target;
         end
      end else if (state_q == ST_FLUSH_PEND) begin
         redirect_c   = 1'b1;
         target_c     = pend_q;
         flush_ifid_c = 1'b1;
         flush_idex_c = 1'b1;
         state_d      = ST_RUN;
      end else if (bus.ex_br) begin
         redirect_c   = 1'b1;
         target_c     = bus.br_target;
         flush_ifid_c = 1'b1;
         flush_idex_c = 1'b1;
      end else if (bus.id_req) begin
         stall_c      = 5'b00011;
         flush_idex_c = 1'b1;
      end else if (bus.if_req) begin
         stall_c      = 5'b00001;
         flush_ifid_c = 1'b1;
      end
   end

   assign bus.stall       = stall_c;
   assign bus.flush_ifid  = flush_ifid_c;
   assign bus.flush_idex  = flush_idex_c;
   assign bus.pc_redirect = redirect_c;
   assign bus.pc_target   = target_c;

`ifdef STALL_CNT_EN
   localparam int unsigned SCNT_W = 32;
   localparam int unsigned RCNT_W = 16;

   logic [SCNT_W-1:0] stall_cycles_q;
   logic [RCNT_W-1:0] redirect_cnt_q;

   // Saturating performance counters
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         stall_cycles_q <= '0;
         redirect_cnt_q <= '0;
      end else begin
         if (bus.rdy_in && stall_c[0] && (stall_cycles_q != '1))
            stall_cycles_q <= stall_cycles_q + SCNT_W'(1);
         if (redirect_c && (redirect_cnt_q != '1))
            redirect_cnt_q <= redirect_cnt_q + RCNT_W'(1);
      end
   end

   assign bus.stall_cycles = stall_cycles_q;
   assign bus.redirect_cnt = redirect_cnt_q;
`endif
endmodule

// File: doc/stall_ctrl.md
STALL_CTRL -- requirements
Module: stall_ctrl

Interface
REQ-001 SHALL have ports: clk_in  in  1  single clock, all state on rising edge.
REQ-002 SHALL have ports: rst_in  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have ports: rdy_in  in  1  global ready; low freezes the pipeline.
REQ-004 SHALL have ports: if_req  in  1  fetch not ready.
REQ-005 SHALL have ports: id_req  in  1  load-use hazard in ID.
REQ-006 SHALL have ports: mem_req  in  1  memory stage busy; same signal drives the MEM/WB register busy input.
REQ-007 SHALL have ports: ex_br  in  1  EX resolved taken branch/jump.
REQ-008 SHALL have ports: br_target  in  32  redirect address from EX.
REQ-009 SHALL have ports: stall  out  5  hold vector; bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB.
REQ-010 SHALL have ports: flush_ifid, flush_idex  out  1 each  load bubble into that register.
REQ-011 SHALL have ports: pc_redirect  out  1, pc_target  out  32  load PC with pc_target.

Function
REQ-012 Outputs SHALL be combinational from current inputs and state (same-cycle effect); state SHALL be RUN or FLUSH_PEND, plus 32-bit pend_target.
REQ-013 Priority, highest first: rst_in, rdy_in low, mem_req, FLUSH_PEND, ex_br, id_req, if_req, idle.
REQ-014 rdy_in=0: stall=5'b11111, flushes and pc_redirect 0, all state held.
REQ-015 mem_req=1: stall=5'b01111, flushes and pc_redirect 0.
REQ-016 mem_req=1 with ex_br=1 in RUN: next state FLUSH_PEND, pend_target<=br_target.
REQ-017 mem_req=1 in FLUSH_PEND: ex_br and br_target ignored; pend_target unchanged.
REQ-018 FLUSH_PEND, mem_req=0, rdy_in=1: stall=0, pc_redirect=1, pc_target=pend_target, flush_ifid=flush_idex=1; next state RUN; ex_br ignored that cycle.
REQ-019 RUN, ex_br=1: stall=0, pc_redirect=1, pc_target=br_target, both flushes 1; id_req, if_req ignored.
REQ-020 RUN, id_req=1 (no ex_br): stall=5'b00011, flush_idex=1.
REQ-021 RUN, if_req=1 only: stall=5'b00001, flush_ifid=1.
REQ-022 Idle: all outputs 0.
REQ-023 pc_target SHALL be 0 whenever pc_redirect=0.

Reset
REQ-024 rst_in high SHALL immediately force state RUN, pend_target 0, counters 0.
REQ-025 While rst_in high all outputs SHALL be 0 irrespective of inputs.
REQ-026 Reset during FLUSH_PEND SHALL discard the pending redirect.

Configuration
REQ-027 With STALL_CNT_EN defined: outputs stall_cycles (out 32) and redirect_cnt (out 16) SHALL exist.
REQ-028 stall_cycles SHALL increment each clock with rdy_in=1 and stall[0]=1.
REQ-029 redirect_cnt SHALL increment each clock with pc_redirect=1.
REQ-030 Both counters SHALL saturate at all-ones; reset clears them.
REQ-031 Without STALL_CNT_EN: ports and counter logic absent; all other behaviour identical.

Verification
REQ-032 Bench SHALL cover id_req=1 one cycle -> stall=00011, flush_idex=1; next cycle idle all 0.
REQ-033 Bench SHALL cover mem_req=1 for 3 cycles with ex_br=1, br_target=0x00001000 in cycle 1 and ex_br=1, br_target=0x00002000 in cycle 2 -> stall=01111 for 3 cycles, no redirect; cycle 4 pc_redirect=1, pc_target=0x00001000, both flushes 1; cycle 5 RUN.
REQ-034 Bench SHALL cover ex_br=1, id_req=1, if_req=1 together in RUN -> pc_redirect=1, stall=00000, both flushes 1.
REQ-035 Bench SHALL cover rdy_in=0 during FLUSH_PEND, mem_req=0 -> stall=11111, no redirect; rdy_in=1 next cycle -> redirect issued.
REQ-036 Bench SHALL cover rst_in asserted mid-cycle in FLUSH_PEND -> outputs 0 at once; after release with mem_req=0, no redirect.
REQ-037 Bench SHALL cover, with STALL_CNT_EN, 5 mem_req cycles and 2 redirects -> stall_cycles=5, redirect_cnt=2.
